logic_response_checker: RTL and testbench
=========================================

# logic_response_checker

Self-checking response monitor for single-bit logic-gate labs. It is the receiving end of the stimulus/response pair: a stimulus source drives the gate under test, and this block samples that stimulus alongside the gate's output. It compares the output each cycle against the expected function (inversion by default), after a programmable settle window and pipeline latency. It counts samples and mismatches, records the first failing sample index, and reports pass/fail at end of run.

## Interface
- `LATENCY`, default 1: cycles from stimulus change to valid response; range 0–7.
- `SETTLE`, default 10: cycles ignored after `start` (reset/settle window).
- `CNT_W`, default 16: width of all counters.
- `INVERT`, default 1: 1 means expected = ~stimulus; 0 means expected = stimulus.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: reset is synchronous and active-high; one clock; clears all state.
- `start`, in, 1: pulse; begins a run (ignored unless IDLE or DONE).
- `runLength`, in, CNT_W: number of samples to check; latched on `start`.
- `stimulus`, in, 1: stimulus bit driven to the gate under test.
- `response`, in, 1: gate output.
- `busy`, out, 1: high in SETTLE or CHECK.
- `done`, out, 1: high in DONE; held until next `start` or `reset`.
- `pass`, out, 1: valid when `done`; 1 iff `errCount` == 0 and `runLength` != 0.
- `errPulse`, out, 1: single-cycle pulse on each mismatching sample.
- `sampleCount`, out, CNT_W: samples checked in current/last run.
- `errCount`, out, CNT_W: mismatches; saturates at all-ones.
- `firstErrIdx`, out, CNT_W: sampleCount value at first mismatch; all-ones if none.

## Operation
- States: IDLE → SETTLE → CHECK → DONE → (start) SETTLE.
- IDLE: outputs at reset values; `start` latches `runLength`, clears counters, sets `firstErrIdx` to all-ones, enters SETTLE.
- SETTLE: settle counter runs SETTLE cycles, then CHECK. SETTLE=0 goes straight to CHECK on the cycle after `start`.
- Expected pipeline: `stimulus` passes through a LATENCY-deep shift register, always clocked (also in IDLE), reset to 0. expected = delayed stimulus XOR INVERT. LATENCY=0 compares combinationally in the same cycle.
- CHECK: each cycle, compare `response` to expected; increment `sampleCount`. On mismatch: pulse `errPulse`, increment `errCount` (saturating). If this is the first error, load `firstErrIdx` with the pre-increment `sampleCount`.
- CHECK exits to DONE in the cycle after `sampleCount` reaches `runLength`. `runLength`=0 goes SETTLE→DONE with `pass`=0.
- DONE: counters frozen; `done`=1. A `start` in DONE begins a new run (clears counters).
- `start` during SETTLE/CHECK is ignored.
- `sampleCount` never exceeds `runLength`; no wrap.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `errPulse`=0, `sampleCount`=0, `errCount`=0, `firstErrIdx`=all-ones; FSM=IDLE; delay line=0.
- `reset` asserted mid-run: next edge forces IDLE and reset values; no `done` is produced.
- `start` at edge N: `busy`=1 from N+1. First compared sample at edge N+1+SETTLE.
- Last sample at edge N+SETTLE+runLength; `done`=1 and `busy`=0 from the following cycle.
- `errPulse` and counter updates are registered: visible the cycle after the sampled edge.
- `pass` is registered on entry to DONE.
- Simultaneous mismatch and last sample: the error is counted and reflected in `pass`.
- Simultaneous `reset` and `start`: `reset` wins.

## Test plan
- Correct inverter model, LATENCY=1, SETTLE=10, runLength=20, stimulus toggling 0→1 every 3 cycles → `done` 31 cycles after `start`; `sampleCount`=20, `errCount`=0, `pass`=1, `firstErrIdx`=0xFFFF.
- Response stuck-at-0, same stimulus, runLength=6, stimulus pattern 0,0,0,1,1,1 (aligned) → `errCount`=3, `firstErrIdx`=0, three `errPulse`s, `pass`=0.
- Single injected fault at sample 7 of runLength=16 → `errCount`=1, `firstErrIdx`=7, one `errPulse`.
- CNT_W=4, response always wrong, runLength=15, then second run of 15 → `errCount` saturates at 15, not wrapping; second `start` in DONE clears it first.
- `reset` asserted at sample 5 of runLength=10 → next cycle all outputs at reset values, FSM=IDLE, `done` never asserted. A subsequent `start` during a run is ignored.
- runLength=0, SETTLE=0 → `done` two cycles after `start`, `sampleCount`=0, `pass`=0.

Source files
------------

// File: rtl/logic_response_checker.sv
// Response monitor for single-bit gate labs: compares the gate output against the
// (optionally inverted) delayed stimulus and reports sample/error counts and pass/fail.
module logic_response_checker #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned SETTLE  = 10,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned INVERT  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] runLength,
  input  logic             stimulus,
  input  logic             response,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             errPulse,
  output logic [CNT_W-1:0] sampleCount,
  output logic [CNT_W-1:0] errCount,
  output logic [CNT_W-1:0] firstErrIdx
);

  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [SET_W-1:0] settle_cnt, settle_n;
  logic [CNT_W-1:0] run_len, run_len_n;
  logic [CNT_W-1:0] sample_n, err_n, first_n;
  logic             busy_n, done_n, pass_n, pulse_n;
  logic             delayed, expected, mismatch;

  // Stimulus delay line, clocked in every state so it is primed before a run.
  generate
    if (LATENCY == 0) begin : g_nodly
      assign delayed = stimulus;
    end else if (LATENCY == 1) begin : g_dly1
      logic dly;
      always_ff @(posedge clk) begin
        if (reset) dly <= 1'b0;
        else       dly <= stimulus;
      end
      assign delayed = dly;
    end else begin : g_dlyn
      logic [LATENCY-1:0] dly;
      always_ff @(posedge clk) begin
        if (reset) dly <= '0;
        else       dly <= {dly[LATENCY-2:0], stimulus};
      end
      assign delayed = dly[LATENCY-1];
    end
  endgenerate

  assign expected = delayed ^ (INVERT != 0);
  assign mismatch = response != expected;

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    settle_n  = settle_cnt;
    run_len_n = run_len;
    sample_n  = sampleCount;
    err_n     = errCount;
    first_n   = firstErrIdx;
    pulse_n   = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          run_len_n = runLength;
          sample_n  = '0;
          err_n     = '0;
          first_n   = '1;
          settle_n  = '0;
          state_n   = (SETTLE == 0) ? S_CHECK : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == SET_W'(SETTLE - 1)) begin
          state_n = (run_len == '0) ? S_DONE : S_CHECK;
        end else begin
          settle_n = settle_cnt + SET_W'(1);
        end
      end
      S_CHECK: begin
        // Only a zero-length run with no settle window reaches CHECK already complete.
        if (sampleCount == run_len) begin
          state_n = S_DONE;
        end else begin
          sample_n = sampleCount + CNT_W'(1);
          if (mismatch) begin
            pulse_n = 1'b1;
            if (errCount != '1) err_n = errCount + CNT_W'(1);
            if (errCount == '0) first_n = sampleCount;
          end
          if (sample_n == run_len) state_n = S_DONE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n == S_SETTLE) || (state_n == S_CHECK);
    done_n = (state_n == S_DONE);
    pass_n = done_n && (err_n == '0) && (run_len_n != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      settle_cnt  <= '0;
      run_len     <= '0;
      sampleCount <= '0;
      errCount    <= '0;
      firstErrIdx <= '1;
      errPulse    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      state       <= state_n;
      settle_cnt  <= settle_n;
      run_len     <= run_len_n;
      sampleCount <= sample_n;
      errCount    <= err_n;
      firstErrIdx <= first_n;
      errPulse    <= pulse_n;
      busy        <= busy_n;
      done        <= done_n;
      pass        <= pass_n;
    end
  end

endmodule

// File: tb/tb_logic_response_checker.sv
// Bench for logic_response_checker: default instance plus a narrow, zero-latency,
// zero-settle, non-inverting instance, both checked against a log-based reference model.
module tb_logic_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start4, stimulus, response;
  logic [15:0] run_len;
  logic [3:0]  run_len4;
  logic        busy, done, pass, err_pulse;
  logic [15:0] sample_count, err_count, first_err_idx;
  logic        busy4, done4, pass4, err_pulse4;
  logic [3:0]  sample_count4, err_count4, first_err_idx4;

  logic_response_checker dut (
    .clk(clk), .reset(reset), .start(start), .runLength(run_len),
    .stimulus(stimulus), .response(response),
    .busy(busy), .done(done), .pass(pass), .errPulse(err_pulse),
    .sampleCount(sample_count), .errCount(err_count), .firstErrIdx(first_err_idx)
  );

  logic_response_checker #(.LATENCY(0), .SETTLE(0), .CNT_W(4), .INVERT(0)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .runLength(run_len4),
    .stimulus(stimulus), .response(response),
    .busy(busy4), .done(done4), .pass(pass4), .errPulse(err_pulse4),
    .sampleCount(sample_count4), .errCount(err_count4), .firstErrIdx(first_err_idx4)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic stim_log [0:8191];
  logic resp_log [0:8191];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Present inputs for edge number cyc, clock it, then settle past the edge.
  task automatic step(input logic s, input logic r);
    stimulus = s;
    response = r;
    stim_log[cyc] = s;
    resp_log[cyc] = r;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Expected gate output at edge e from the stimulus history.
  function automatic logic expv(input int e, input int lat, input int inv);
    logic iv;
    iv = (inv != 0);
    if (lat == 0) return stim_log[e] ^ iv;
    return stim_log[e - lat] ^ iv;
  endfunction

  // One complete run on instance sel; smode: 0 random, 1 toggle every 3, 2 aligned 000111.
  // rmode: 0 correct, 1 stuck-at-0, 2 single fault at sample fi, 3 random faults, 4 always wrong.
  task automatic run(input int sel, input int len, input int smode, input int rmode,
                     input int fi, input bit ign, input string tag);
    int   lat, st, inv, maxc, n, de, e, p, cnt, first, sc_exp;
    logic s, r, ex, mis;
    logic o_pulse, o_busy, o_done, o_pass;
    logic [15:0] o_sc, o_ec, o_fi;
    lat  = (sel != 0) ? 0 : 1;
    st   = (sel != 0) ? 0 : 10;
    inv  = (sel != 0) ? 0 : 1;
    maxc = (sel != 0) ? 15 : 65535;
    n    = cyc;
    de   = (len == 0 && st == 0) ? n + 1 : n + st + len;
    if (sel != 0) begin run_len4 = 4'(len); start4 = 1'b1; end
    else          begin run_len  = 16'(len); start = 1'b1; end
    for (int k = 0; k < len + st + 4; k++) begin
      e = cyc;
      if (k > 0) begin start = 1'b0; start4 = 1'b0; end
      if (k == 1) begin run_len = 16'($urandom); run_len4 = 4'($urandom); end
      if (ign && e == n + st + 2) begin
        if (sel != 0) start4 = 1'b1; else start = 1'b1;
      end
      case (smode)
        0: s = 1'($urandom);
        1: s = 1'(((e - n) / 3) % 2);
        default: begin p = e - n - st; s = (p >= 3 && p < 6); end
      endcase
      stim_log[e] = s;
      ex = expv(e, lat, inv);
      case (rmode)
        0: r = ex;
        1: r = 1'b0;
        2: r = ex ^ (e == n + 1 + st + fi);
        3: r = ex ^ ($urandom_range(0, 3) == 0);
        default: r = ~ex;
      endcase
      step(s, r);
      mis = (e > n + st) && (e <= n + st + len) && (resp_log[e] !== expv(e, lat, inv));
      sc_exp = e - n - st;
      if (sc_exp < 0) sc_exp = 0;
      if (sc_exp > len) sc_exp = len;
      o_pulse = (sel != 0) ? err_pulse4 : err_pulse;
      o_busy  = (sel != 0) ? busy4 : busy;
      o_done  = (sel != 0) ? done4 : done;
      o_sc    = (sel != 0) ? 16'(sample_count4) : sample_count;
      chk({tag, ".errPulse"}, 32'(o_pulse), 32'(mis));
      chk({tag, ".busy"}, 32'(o_busy), 32'(e >= n && e < de));
      chk({tag, ".done"}, 32'(o_done), 32'(e >= de));
      chk({tag, ".sampleCount"}, 32'(o_sc), 32'(sc_exp));
      if (e >= de) break;
    end
    start = 1'b0;
    start4 = 1'b0;
    cnt = 0;
    first = -1;
    for (int j = 0; j < len; j++) begin
      e = n + 1 + st + j;
      if (resp_log[e] !== expv(e, lat, inv)) begin
        if (first < 0) first = j;
        cnt++;
      end
    end
    if (cnt > maxc) cnt = maxc;
    if (first < 0) first = maxc;
    for (int k = 0; k < 2; k++) begin
      o_busy = (sel != 0) ? busy4 : busy;
      o_done = (sel != 0) ? done4 : done;
      o_pass = (sel != 0) ? pass4 : pass;
      o_sc   = (sel != 0) ? 16'(sample_count4) : sample_count;
      o_ec   = (sel != 0) ? 16'(err_count4) : err_count;
      o_fi   = (sel != 0) ? 16'(first_err_idx4) : first_err_idx;
      chk({tag, ".final.done"}, 32'(o_done), 32'd1);
      chk({tag, ".final.busy"}, 32'(o_busy), 32'd0);
      chk({tag, ".final.sampleCount"}, 32'(o_sc), 32'(len));
      chk({tag, ".final.errCount"}, 32'(o_ec), 32'(cnt));
      chk({tag, ".final.firstErrIdx"}, 32'(o_fi), 32'(first));
      chk({tag, ".final.pass"}, 32'(o_pass), 32'(len != 0 && cnt == 0));
      step(1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; start4 = 1'b0; run_len = '0; run_len4 = '0;
    stimulus = 1'b0; response = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    reset = 1'b0;

    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.pass", 32'(pass), 32'd0);
    chk("rst.errPulse", 32'(err_pulse), 32'd0);
    chk("rst.sampleCount", 32'(sample_count), 32'd0);
    chk("rst.errCount", 32'(err_count), 32'd0);
    chk("rst.firstErrIdx", 32'(first_err_idx), 32'hFFFF);
    chk("rst4.firstErrIdx", 32'(first_err_idx4), 32'hF);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    chk("idle.busy", 32'(busy), 32'd0);

    run(0, 20, 1, 0, 0, 1'b0, "good_inv");
    run(0, 6, 2, 1, 0, 1'b0, "stuck0");
    run(0, 16, 0, 2, 7, 1'b0, "fault7");
    for (int i = 0; i < 6; i++) run(0, $urandom_range(3, 40), 0, 3, 0, i == 2, "rand");
    run(0, 0, 0, 0, 0, 1'b0, "len0_settle");
    run(1, 15, 0, 4, 0, 1'b0, "sat1");
    run(1, 15, 0, 4, 0, 1'b0, "sat2");
    run(1, 5, 0, 0, 0, 1'b0, "after_sat");
    run(1, 0, 0, 0, 0, 1'b0, "len0");
    for (int i = 0; i < 3; i++) run(1, $urandom_range(3, 15), 0, 3, 0, i == 1, "rand4");

    // Reset at sample 5 of a 10-sample run, with a colliding start.
    run_len = 16'd10;
    start = 1'b1;
    n = cyc;
    step(1'b0, 1'b0);
    start = 1'b0;
    while (cyc < n + 16) step(1'($urandom), 1'b0);
    reset = 1'b1;
    start = 1'b1;
    step(1'($urandom), 1'b0);
    reset = 1'b0;
    start = 1'b0;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.pass", 32'(pass), 32'd0);
    chk("midrst.errPulse", 32'(err_pulse), 32'd0);
    chk("midrst.sampleCount", 32'(sample_count), 32'd0);
    chk("midrst.errCount", 32'(err_count), 32'd0);
    chk("midrst.firstErrIdx", 32'(first_err_idx), 32'hFFFF);
    for (int k = 0; k < 12; k++) begin
      step(1'($urandom), 1'b0);
      chk("midrst.idle.done", 32'(done), 32'd0);
      chk("midrst.idle.busy", 32'(busy), 32'd0);
    end
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0);
    run(0, 10, 0, 3, 0, 1'b1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
